// File: rtl/cfa_buf_pkg.sv
// Shared helpers for the CFA window buffer: width math, window tap slicing and Bayer phase codes.
package cfa_buf_pkg;

  // Bayer phase of a pixel for an RGGB mosaic, encoded as {row[0], col[0]}
  typedef enum logic [1:0] {
    PH_R  = 2'b00,
    PH_GR = 2'b01,
    PH_GB = 2'b10,
    PH_B  = 2'b11
  } cfa_phase_e;

  // Address width for a store of v entries (never less than one bit)
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned x = 1; x < v; x = x << 1) begin
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // LSB position of window tap (r,c) inside the flattened window bus
  function automatic int unsigned tap_lsb(input int r, input int c,
                                          input int unsigned win, input int unsigned pix_w);
    return (int'(r) * int'(win) + int'(c)) * int'(pix_w);
  endfunction

  function automatic cfa_phase_e phase_of(input logic row_lsb, input logic col_lsb);
    return cfa_phase_e'({row_lsb, col_lsb});
  endfunction

endpackage

// File: rtl/cfa_line_ram.sv
// One circular line of pixels, addressed by column; read is combinational so the
// old pixel is available in the same cycle it gets overwritten.
module cfa_line_ram
  import cfa_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 4
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [clog2(DEPTH)-1:0]  addr,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // Contents are don't-care after reset; no reset on the storage array
  always_ff @(posedge clk) begin
    if (en) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/cfa_window_buffer.sv
// Line buffer and WIN x WIN sliding-window generator for the CFA demosaic path.
// Optional BORDER_PAD_EN: every pixel yields a window, out-of-image taps read as zero.
module cfa_window_buffer
  import cfa_buf_pkg::*;
#(
  parameter int unsigned PIX_W = 4,
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 6,
  parameter int unsigned WIN   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      sof,
  input  logic [PIX_W-1:0]          d_in,
  output logic [WIN*WIN*PIX_W-1:0]  win_data,
  output logic                      win_valid,
  output logic [1:0]                cfa_phase,
  output logic                      eof
);

  localparam int unsigned COL_W    = clog2(IMG_W);
  localparam int unsigned ROW_W    = clog2(IMG_H);
  localparam int unsigned NLINE    = WIN - 1;
  localparam int unsigned WIN_BITS = WIN * WIN * PIX_W;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [ROW_W-1:0] row_q, cur_row, row_d;
  logic [COL_W-1:0] col_q, cur_col, col_d;
  logic             line_end, frame_end;

  logic [NLINE-1:0][PIX_W-1:0] line_rd;
  logic [NLINE-1:0][PIX_W-1:0] line_wr;
  logic [WIN-1:0][PIX_W-1:0]   col_pix;

  logic [WIN_BITS-1:0] shift_q, shift_d, mask_d;
  logic                valid_d;

  // Position of the pixel being accepted; sof re-syncs it to (0,0)
  always_comb begin
    cur_row   = sof ? '0 : row_q;
    cur_col   = sof ? '0 : col_q;
    line_end  = (cur_col == COL_LAST);
    frame_end = line_end && (cur_row == ROW_LAST);
    col_d     = line_end ? '0 : cur_col + COL_W'(1);
    row_d     = cur_row;
    if (frame_end) begin
      row_d = '0;
    end else if (line_end) begin
      row_d = cur_row + ROW_W'(1);
    end
  end

  // Line k holds row-1-k; each line's evicted pixel cascades into the next older line
  for (genvar k = 0; k < NLINE; k++) begin : g_line
    if (k == 0) begin : g_first
      assign line_wr[k] = d_in;
    end else begin : g_chain
      assign line_wr[k] = line_rd[k-1];
    end

    cfa_line_ram #(
      .DEPTH (IMG_W),
      .W     (PIX_W)
    ) u_ram (
      .clk   (clk),
      .en    (en),
      .addr  (cur_col),
      .wdata (line_wr[k]),
      .rdata (line_rd[k])
    );
  end

  // Newest window column, window row 0 = oldest line
  for (genvar r = 0; r < WIN; r++) begin : g_col
    if (r == WIN - 1) begin : g_new
      assign col_pix[r] = d_in;
    end else begin : g_old
      assign col_pix[r] = line_rd[WIN-2-r];
    end
  end

  // Shift every window row one column left and append the new column on the right
  always_comb begin
    shift_d = shift_q;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN - 1; c++) begin
        shift_d[tap_lsb(r, c, WIN, PIX_W) +: PIX_W] = shift_q[tap_lsb(r, c + 1, WIN, PIX_W) +: PIX_W];
      end
      shift_d[tap_lsb(r, WIN - 1, WIN, PIX_W) +: PIX_W] = col_pix[r];
    end
  end

`ifdef BORDER_PAD_EN
  // Taps above or left of the image read as zero, so stale wrap data never leaks out
  always_comb begin
    mask_d  = shift_d;
    valid_d = 1'b1;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        if ((int'(cur_row) < int'(WIN) - 1 - r) || (int'(cur_col) < int'(WIN) - 1 - c)) begin
          mask_d[tap_lsb(r, c, WIN, PIX_W) +: PIX_W] = PIX_W'(0);
        end
      end
    end
  end
`else
  localparam logic [COL_W-1:0] COL_EDGE = COL_W'(WIN - 1);
  localparam logic [ROW_W-1:0] ROW_EDGE = ROW_W'(WIN - 1);

  // Only windows lying fully inside the current frame are flagged valid
  always_comb begin
    mask_d  = shift_d;
    valid_d = (cur_row >= ROW_EDGE) && (cur_col >= COL_EDGE);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q     <= '0;
      col_q     <= '0;
      shift_q   <= '0;
      win_data  <= '0;
      win_valid <= 1'b0;
      cfa_phase <= 2'b00;
      eof       <= 1'b0;
    end else begin
      win_valid <= en && valid_d;
      eof       <= en && frame_end;
      if (en) begin
        row_q     <= row_d;
        col_q     <= col_d;
        shift_q   <= shift_d;
        win_data  <= mask_d;
        cfa_phase <= phase_of(cur_row[0], cur_col[0]);
      end
    end
  end

endmodule

// File: tb/tb_cfa_window_buffer.sv
// Directed self-checking bench for cfa_window_buffer (PIX_W=4, IMG_W=8, IMG_H=6, WIN=3).
// Honours BORDER_PAD_EN when the design is built with it.
module tb_cfa_window_buffer;

  localparam int unsigned PIX_W = 4;
  localparam int unsigned IMG_W = 8;
  localparam int unsigned IMG_H = 6;
  localparam int unsigned WIN   = 3;
`ifdef BORDER_PAD_EN
  localparam bit PAD        = 1'b1;
  localparam int EXP_PULSES = 48;
`else
  localparam bit PAD        = 1'b0;
  localparam int EXP_PULSES = 24;
`endif

  logic                     clk;
  logic                     rst;
  logic                     en;
  logic                     sof;
  logic [PIX_W-1:0]         d_in;
  logic [WIN*WIN*PIX_W-1:0] win_data;
  logic                     win_valid;
  logic [1:0]               cfa_phase;
  logic                     eof;

  int n_tests;
  int n_fail;

  cfa_window_buffer #(
    .PIX_W (PIX_W),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .WIN   (WIN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sof       (sof),
    .d_in      (d_in),
    .win_data  (win_data),
    .win_valid (win_valid),
    .cfa_phase (cfa_phase),
    .eof       (eof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] pix(input int r, input int c);
    return 4'((8 * r + c) % 16);
  endfunction

  // Window ending at (r,c); taps outside the image are zero
  function automatic logic [35:0] exp_win(input int r, input int c);
    logic [35:0] w;
    int pr;
    int pc;
    w = '0;
    for (int tr = 0; tr < 3; tr++) begin
      for (int tc = 0; tc < 3; tc++) begin
        pr = r - 2 + tr;
        pc = c - 2 + tc;
        if (pr >= 0 && pc >= 0) w[(tr * 3 + tc) * 4 +: 4] = pix(pr, pc);
      end
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the falling edge, then sample 1 time unit after the rising edge
  task automatic step(input logic e, input logic s, input logic [3:0] d);
    @(negedge clk);
    en   = e;
    sof  = s;
    d_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_pixel(input int r, input int c);
    logic exp_valid;
    exp_valid = PAD ? 1'b1 : (r >= 2 && c >= 2);
    check("valid", 64'(win_valid), 64'(exp_valid));
    check("eof", 64'(eof), 64'(r == 5 && c == 7));
    check("phase", 64'(cfa_phase), 64'({r[0], c[0]}));
    if (exp_valid) check("win", 64'(win_data), 64'(exp_win(r, c)));
    if (r == 2 && c == 2) check("ramp_2_2", 64'(win_data), 64'(36'h210A98210));
    if (r == 3 && c == 2) check("wrap_3_2", 64'(win_data), 64'(36'hA98210A98));
  endtask

  task automatic run_frame(input bit gap);
    int pulses;
    pulses = 0;
    for (int r = 0; r < int'(IMG_H); r++) begin
      for (int c = 0; c < int'(IMG_W); c++) begin
        step(1'b1, (r == 0 && c == 0), pix(r, c));
        check_pixel(r, c);
        if (win_valid) pulses++;
        if (gap && r == 3 && c == 4) begin
          for (int g = 0; g < 3; g++) begin
            step(1'b0, 1'b0, 4'hF);
            check("gap_valid", 64'(win_valid), 64'(0));
            check("gap_eof", 64'(eof), 64'(0));
            check("gap_hold", 64'(win_data), 64'(exp_win(3, 4)));
            check("gap_phase", 64'(cfa_phase), 64'(2'b10));
          end
        end
      end
    end
    check("pulses", 64'(pulses), 64'(EXP_PULSES));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst  = 1'b0;
    en   = 1'b0;
    sof  = 1'b0;
    d_in = '0;
    #12;
    check("rst_win", 64'(win_data), 64'(0));
    check("rst_valid", 64'(win_valid), 64'(0));
    check("rst_phase", 64'(cfa_phase), 64'(0));
    check("rst_eof", 64'(eof), 64'(0));

    @(negedge clk);
    rst = 1'b1;

    run_frame(1'b0);
    step(1'b0, 1'b0, 4'h0);
    check("eof_clear", 64'(eof), 64'(0));
    run_frame(1'b1);

    // Async reset in the middle of line 4
    for (int r = 0; r <= 4; r++) begin
      for (int c = 0; c < int'(IMG_W); c++) begin
        if (r < 4 || c <= 3) begin
          step(1'b1, (r == 0 && c == 0), pix(r, c));
          check_pixel(r, c);
        end
      end
    end
    #2;
    rst = 1'b0;
    #1;
    check("arst_win", 64'(win_data), 64'(0));
    check("arst_valid", 64'(win_valid), 64'(0));
    check("arst_phase", 64'(cfa_phase), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    // Restart with sof: first full window again at (2,2)
    for (int r = 0; r <= 2; r++) begin
      for (int c = 0; c < int'(IMG_W); c++) begin
        if (r < 2 || c <= 2) begin
          step(1'b1, (r == 0 && c == 0), pix(r, c));
          check_pixel(r, c);
        end
      end
    end

`ifdef BORDER_PAD_EN
    step(1'b1, 1'b1, 4'h5);
    check("pad_valid", 64'(win_valid), 64'(1));
    check("pad_win", 64'(win_data), 64'(36'h500000000));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
